fizzbuzz_ascii_tx: RTL and testbench

//  Consumer end of the fizzbuzz generator stream. Accepts one (number, is_fizz, is_buzz)

---
 rtl/fizzbuzz_pkg.sv | 33 +++
 rtl/fizzbuzz_bin2bcd.sv | 67 ++++++
 rtl/fizzbuzz_ascii_tx.sv | 182 ++++++++++++++++++
 tb/tb_fizzbuzz_ascii_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the fizzbuzz ASCII line transmitter.
package fizzbuzz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        TEXT,
        DIGITS,
        NL
    } fb_state_t;

    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_I  = 8'h69;
    localparam logic [7:0] ASCII_Z  = 8'h7A;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_U  = 8'h75;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Number of decimal digits needed to print a non-negative value (0 -> 1).
    function automatic int num_dec_digits(input int value);
        int n;
        int v;
        n = 1;
        v = value;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fizzbuzz_bin2bcd.sv
// Sequential double-dabble converter: W-bit binary in, D BCD digits out.
// The first shift happens on the start edge, so o_done is high exactly
// W cycles after the cycle in which i_start is asserted. o_bcd holds its
// value until the next start.
module fizzbuzz_bin2bcd
    import fizzbuzz_pkg::*;
#(
    parameter int W = 5,
    parameter int D = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_bin,
    output logic           o_done,
    output logic [D*4-1:0] o_bcd
);

    // Internal digit count covers the full W-bit range so out-of-range
    // inputs do not corrupt the shift chain; only the low D digits leave.
    localparam int DF    = num_dec_digits((1 << W) - 1);
    localparam int DI    = (DF > D) ? DF : D;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     bin_q;
    logic [DI*4-1:0]  bcd_q;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    function automatic logic [DI*4-1:0] dabble_adjust(input logic [DI*4-1:0] v);
        logic [DI*4-1:0] r;
        r = v;
        for (int k = 0; k < DI; k++) begin
            if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Control: busy flag and remaining-shift counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (i_start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(W - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

    // Datapath: load with the first shift applied, then adjust-and-shift.
    always_ff @(posedge i_clk) begin
        if (i_start) begin
            bcd_q <= {{(DI*4-1){1'b0}}, i_bin[W-1]};
            bin_q <= i_bin << 1;
        end else if (busy_q && (cnt_q != '0)) begin
            {bcd_q, bin_q} <= {dabble_adjust(bcd_q), bin_q} << 1;
        end
    end

    assign o_done = busy_q && (cnt_q == '0);
    assign o_bcd  = bcd_q[D*4-1:0];

endmodule

// File: rtl/fizzbuzz_ascii_tx.sv
// Serialises fizzbuzz beats into ASCII lines ("Fizz", "Buzz", "FizzBuzz"
// or the decimal number) on a byte stream, each line ended by LF with
// o_last. All outputs are registered; o_data/o_last hold while stalled.
module fizzbuzz_ascii_tx
    import fizzbuzz_pkg::*;
#(
    parameter  int g_length = 20,
    localparam int W        = $clog2(g_length + 1),
    localparam int D        = num_dec_digits(g_length)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_number,
    input  logic         i_is_fizz,
    input  logic         i_is_buzz,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [7:0]   o_data,
    output logic         o_last,
    output logic         o_err
);

    localparam int IDX_W = (D > 8) ? $clog2(D) : 3;

    fb_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc, idx_dec;
    logic [IDX_W-1:0] lead_pos, text_last;
    logic             fizz_q, buzz_q;
    logic             ready_d, valid_d, last_d, err_d;
    logic [7:0]       data_d;
    logic             accept, in_bad;
    logic             conv_start, conv_done;
    logic [D*4-1:0]   bcd;

    // Text byte at position idx: the "Fizz" half first when fizz is set.
    function automatic logic [7:0] text_byte(input logic [IDX_W-1:0] idx, input logic fizz);
        logic use_fizz;
        use_fizz = fizz && (int'(idx) < 4);
        case (idx[1:0])
            2'd0:    return use_fizz ? ASCII_F : ASCII_B;
            2'd1:    return use_fizz ? ASCII_I : ASCII_U;
            default: return ASCII_Z;
        endcase
    endfunction

    // ASCII character of BCD digit at position pos (0 = least significant).
    function automatic logic [7:0] digit_byte(input logic [D*4-1:0] bcd_v, input logic [IDX_W-1:0] pos);
        return ASCII_0 + {4'd0, bcd_v[int'(pos)*4 +: 4]};
    endfunction

    fizzbuzz_bin2bcd #(
        .W (W),
        .D (D)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (conv_start),
        .i_bin   (i_number),
        .o_done  (conv_done),
        .o_bcd   (bcd)
    );

    assign accept    = (state_q == IDLE) && o_ready && i_valid;
    assign in_bad    = (i_is_fizz != ((int'(i_number) % 3) == 0)) ||
                       (i_is_buzz != ((int'(i_number) % 5) == 0)) ||
                       (int'(i_number) > g_length);
    assign text_last = (fizz_q && buzz_q) ? IDX_W'(7) : IDX_W'(3);
    assign idx_inc   = idx_q + IDX_W'(1);
    assign idx_dec   = idx_q - IDX_W'(1);

    // Leading-zero suppression: position of the most significant nonzero
    // digit, or the LS digit when the value is zero.
    always_comb begin
        lead_pos = '0;
        for (int p = 1; p < D; p++) begin
            if (bcd[p*4 +: 4] != 4'd0) lead_pos = IDX_W'(p);
        end
    end

    // Next-state and next-output logic; output bytes only advance on i_ready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = o_valid;
        data_d     = o_data;
        last_d     = o_last;
        err_d      = o_err;
        conv_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = o_err | in_bad;
                    if (i_is_fizz || i_is_buzz) begin
                        state_d = TEXT;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        data_d  = text_byte('0, i_is_fizz);
                        last_d  = 1'b0;
                    end else begin
                        state_d    = CONV;
                        conv_start = 1'b1;
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = DIGITS;
                    idx_d   = lead_pos;
                    valid_d = 1'b1;
                    data_d  = digit_byte(bcd, lead_pos);
                    last_d  = 1'b0;
                end
            end
            TEXT: begin
                if (i_ready) begin
                    if (idx_q == text_last) begin
                        state_d = NL;
                        data_d  = ASCII_LF;
                        last_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = text_byte(idx_inc, fizz_q);
                    end
                end
            end
            DIGITS: begin
                if (i_ready) begin
                    if (idx_q == '0) begin
                        state_d = NL;
                        data_d  = ASCII_LF;
                        last_d  = 1'b1;
                    end else begin
                        idx_d  = idx_dec;
                        data_d = digit_byte(bcd, idx_dec);
                    end
                end
            end
            NL: begin
                if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // Control and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            o_ready <= ready_d;
            o_valid <= valid_d;
            o_data  <= data_d;
            o_last  <= last_d;
            o_err   <= err_d;
        end
    end

    // Captured flags select the text for the whole line.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            fizz_q <= i_is_fizz;
            buzz_q <= i_is_buzz;
        end
    end

endmodule

// File: tb/tb_fizzbuzz_ascii_tx.sv
// Directed bench for fizzbuzz_ascii_tx with g_length = 20 (W = 5).
module tb_fizzbuzz_ascii_tx;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [4:0] i_number = '0;
    logic       i_is_fizz = 1'b0;
    logic       i_is_buzz = 1'b0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_err;

    int n_chk  = 0;
    int n_pass = 0;
    int ncyc   = 0;
    int acc_cyc = 0;
    bit got_last = 1'b0;
    bit rnd_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    logic [7:0] rx_byte[$];
    logic       rx_last[$];
    int         rx_cyc[$];

    fizzbuzz_ascii_tx #(.g_length(20)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_number  (i_number),
        .i_is_fizz (i_is_fizz),
        .i_is_buzz (i_is_buzz),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_last    (o_last),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Byte monitor on the falling edge: records handshakes, checks stall hold.
    initial begin
        forever begin
            @(negedge i_clk);
            ncyc++;
            if (prev_stall)
                chk("stall_hold", {22'd0, o_valid, o_last, o_data}, {22'd0, 1'b1, prev_last, prev_data});
            if (o_valid && i_ready) begin
                rx_byte.push_back(o_data);
                rx_last.push_back(o_last);
                rx_cyc.push_back(ncyc);
                if (o_last) got_last = 1'b1;
            end
            prev_stall = o_valid && !i_ready && i_rst_n;
            prev_data  = o_data;
            prev_last  = o_last;
            if (i_valid && o_ready) acc_cyc = ncyc;
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_beat(input logic [4:0] num, input logic f, input logic b);
        int t;
        t = 0;
        @(posedge i_clk); #2;
        while (!o_ready && t < 50) begin
            @(posedge i_clk); #2;
            t++;
        end
        chk("ready_wait", {31'd0, o_ready}, 32'd1);
        i_number  = num;
        i_is_fizz = f;
        i_is_buzz = b;
        i_valid   = 1'b1;
        @(posedge i_clk); #2;
        i_valid   = 1'b0;
    endtask

    task automatic run_line(input string tag, input logic [4:0] num, input logic f, input logic b,
                            input string exp, input int lat, input bit consec);
        int n;
        rx_byte.delete();
        rx_last.delete();
        rx_cyc.delete();
        got_last = 1'b0;
        send_beat(num, f, b);
        for (int t = 0; t < 300 && !got_last; t++) @(posedge i_clk);
        #2;
        chk($sformatf("%s_done", tag), {31'd0, got_last}, 32'd1);
        chk($sformatf("%s_len", tag), rx_byte.size(), exp.len());
        n = (rx_byte.size() < exp.len()) ? rx_byte.size() : exp.len();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_byte[i]}, {24'd0, exp[i]});
            chk($sformatf("%s_last%0d", tag, i), {31'd0, rx_last[i]}, (i == exp.len() - 1) ? 32'd1 : 32'd0);
            if (consec) chk($sformatf("%s_gap%0d", tag, i), rx_cyc[i] - rx_cyc[0], i);
        end
        if (lat >= 0 && n > 0) chk($sformatf("%s_lat", tag), rx_cyc[0] - acc_cyc, lat);
    endtask

    initial begin
        int t;
        // Reset state
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data",  {24'd0, o_data},  32'd0);
        chk("rst_last",  {31'd0, o_last},  32'd0);
        chk("rst_err",   {31'd0, o_err},   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rel_ready_pre", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        chk("rel_ready_post", {31'd0, o_ready}, 32'd1);

        // Directed lines with full-rate sink
        run_line("n7",  5'd7,  1'b0, 1'b0, "7\n",        6, 1'b1);
        run_line("n15", 5'd15, 1'b1, 1'b1, "FizzBuzz\n", 1, 1'b1);
        chk("err_n15", {31'd0, o_err}, 32'd0);
        run_line("n13", 5'd13, 1'b0, 1'b0, "13\n",       6, 1'b1);
        run_line("n20", 5'd20, 1'b0, 1'b1, "Buzz\n",     1, 1'b1);
        run_line("n0",  5'd0,  1'b1, 1'b1, "FizzBuzz\n", 1, 1'b1);
        chk("err_n0", {31'd0, o_err}, 32'd0);

        // Random backpressure
        rnd_ready = 1'b1;
        run_line("n9r", 5'd9, 1'b1, 1'b0, "Fizz\n", -1, 1'b0);
        rnd_ready = 1'b0;
        i_ready   = 1'b1;
        chk("err_n9", {31'd0, o_err}, 32'd0);

        // Inconsistent flags: printed per flags, sticky error
        run_line("n4", 5'd4, 1'b1, 1'b0, "Fizz\n", 1, 1'b1);
        chk("err_n4", {31'd0, o_err}, 32'd1);
        run_line("n10", 5'd10, 1'b0, 1'b1, "Buzz\n", 1, 1'b1);
        chk("err_sticky", {31'd0, o_err}, 32'd1);

        // Reset in the middle of a line
        rx_byte.delete();
        rx_last.delete();
        rx_cyc.delete();
        got_last = 1'b0;
        send_beat(5'd15, 1'b1, 1'b1);
        t = 0;
        while (rx_byte.size() < 3 && t < 50) begin
            @(posedge i_clk); #2;
            t++;
        end
        i_rst_n = 1'b0;
        #1;
        chk("mid_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_last",  {31'd0, o_last},  32'd0);
        chk("mid_ready", {31'd0, o_ready}, 32'd0);
        chk("mid_err",   {31'd0, o_err},   32'd0);
        chk("mid_count", rx_byte.size(), 32'd3);
        if (rx_byte.size() >= 3) begin
            chk("mid_b0", {24'd0, rx_byte[0]}, 32'h46);
            chk("mid_b1", {24'd0, rx_byte[1]}, 32'h69);
            chk("mid_b2", {24'd0, rx_byte[2]}, 32'h7A);
        end
        repeat (2) @(posedge i_clk);
        #2;
        chk("mid_no_lf", {31'd0, got_last}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("mid_rel_pre", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        chk("mid_rel_post", {31'd0, o_ready}, 32'd1);
        run_line("n7b", 5'd7, 1'b0, 1'b0, "7\n", 6, 1'b1);
        chk("err_after_rst", {31'd0, o_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
